trigger_seq: RTL and testbench

Parametrised multi-stage SUMP trigger sequencer: next generation of the single trigger stage. Holds `NSTAGES` independently configured stages over a `WIDTH`-channel sample bus. Owns the trigger level counter internally and chains stages via levels. Sits between the command decoder (config/arm flags) and the sampler/capture controller, which starts on `run_o`.

---
 rtl/trigger_seq.sv | 169 ++++++++++++++++
 tb/tb_trigger_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_seq.sv
// trigger_seq: multi-stage SUMP trigger sequencer. Stages chain through an
// internal 2-bit level; any firing stage with act set starts the capture.
module trigger_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NSTAGES = 4,
  parameter int unsigned DLY_W   = 16,
  localparam int unsigned SEL_W  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        cmd_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               set_mask_i,
  input  logic               set_val_i,
  input  logic               set_cfg_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic               stb_i,
  input  logic [WIDTH-1:0]   smpls_i,
  output logic [NSTAGES-1:0] match_o,
  output logic               run_o,
  output logic [1:0]         lvl_o,
  output logic               armed_o
);
  localparam int unsigned CHL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMD, ST_DLY} stage_e;

  logic [WIDTH-1:0] mask_q   [NSTAGES];
  logic [WIDTH-1:0] val_q    [NSTAGES];
  logic [WIDTH-2:0] shft_q   [NSTAGES];
  logic             serial_q [NSTAGES];
  logic             act_q    [NSTAGES];
  logic [1:0]       level_q  [NSTAGES];
  logic [CHL_W-1:0] chl_q    [NSTAGES];
  logic [DLY_W-1:0] dly_q    [NSTAGES];
  logic [DLY_W-1:0] cnt_q    [NSTAGES];
  logic [DLY_W-1:0] cnt_d    [NSTAGES];
  stage_e           state_q  [NSTAGES];
  stage_e           state_d  [NSTAGES];
  logic [WIDTH-1:0] ser_cmp  [NSTAGES];

  logic [NSTAGES-1:0] hit;
  logic [NSTAGES-1:0] fire;
  logic               run_d;
  logic               armed_d;
  logic [1:0]         lvl_q;
  logic [1:0]         lvl_d;

  logic [4:0]       chl_raw;
  logic [15:0]      dly_raw;
  logic [CHL_W-1:0] cfg_chl;
  logic [DLY_W-1:0] cfg_dly;
  logic             unused_cmd;

  assign chl_raw    = {cmd_i[0], cmd_i[15:12]};
  assign dly_raw    = {cmd_i[23:16], cmd_i[31:24]};
  assign cfg_chl    = CHL_W'(chl_raw);
  assign cfg_dly    = DLY_W'(dly_raw);
  assign unused_cmd = ^{cmd_i[1], cmd_i[7:4], cmd_i[11:10]};
  assign lvl_o      = lvl_q;

  // The MSB of the serial window is never fed back, so the shift register
  // only needs WIDTH-1 bits.
  for (genvar g = 0; g < NSTAGES; g++) begin : g_cmp
    logic             sbit;
    logic [WIDTH-1:0] cmp;
    assign sbit       = (32'(chl_q[g]) < WIDTH) ? smpls_i[chl_q[g]] : 1'b0;
    assign ser_cmp[g] = {shft_q[g], sbit};
    assign cmp        = serial_q[g] ? ser_cmp[g] : smpls_i;
    assign hit[g]     = ((cmp ^ val_q[g]) & mask_q[g]) == '0;
  end

  always_comb begin
    fire    = '0;
    run_d   = 1'b0;
    lvl_d   = lvl_q;
    armed_d = 1'b0;
    for (int unsigned i = 0; i < NSTAGES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (stb_i && !arm_i && !disarm_i) begin
        unique case (state_q[i])
          ST_ARMD: begin
            if (lvl_q >= level_q[i] && hit[i]) begin
              if (dly_q[i] == '0) begin
                fire[i] = 1'b1;
              end else begin
                cnt_d[i]   = dly_q[i] - DLY_W'(1);
                state_d[i] = ST_DLY;
              end
            end
          end
          ST_DLY: begin
            if (cnt_q[i] == '0) fire[i] = 1'b1;
            else                cnt_d[i] = cnt_q[i] - DLY_W'(1);
          end
          default: ;
        endcase
      end
      if (fire[i]) begin
        state_d[i] = ST_IDLE;
        if (act_q[i]) run_d = 1'b1;
      end
    end

    // Global events override the per-stage transitions computed above.
    if (disarm_i) begin
      for (int unsigned i = 0; i < NSTAGES; i++) state_d[i] = ST_IDLE;
      lvl_d = '0;
    end else if (arm_i) begin
      for (int unsigned i = 0; i < NSTAGES; i++) begin
        state_d[i] = ST_ARMD;
        cnt_d[i]   = '0;
      end
      lvl_d = '0;
    end else if (run_d) begin
      for (int unsigned i = 0; i < NSTAGES; i++) state_d[i] = ST_IDLE;
    end else if (fire != '0 && lvl_q != 2'd3) begin
      lvl_d = lvl_q + 2'd1;
    end

    for (int unsigned i = 0; i < NSTAGES; i++) begin
      if (state_d[i] != ST_IDLE) armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NSTAGES; i++) begin
        mask_q[i]   <= '0;
        val_q[i]    <= '0;
        shft_q[i]   <= '0;
        serial_q[i] <= 1'b0;
        act_q[i]    <= 1'b0;
        level_q[i]  <= '0;
        chl_q[i]    <= '0;
        dly_q[i]    <= '0;
        cnt_q[i]    <= '0;
        state_q[i]  <= ST_IDLE;
      end
      lvl_q   <= '0;
      match_o <= '0;
      run_o   <= 1'b0;
      armed_o <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NSTAGES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        if (stb_i) shft_q[i] <= ser_cmp[i][WIDTH-2:0];
        if (32'(sel_i) == i) begin
          if (set_mask_i) mask_q[i] <= cmd_i[WIDTH-1:0];
          if (set_val_i)  val_q[i]  <= cmd_i[WIDTH-1:0];
          if (set_cfg_i) begin
            serial_q[i] <= cmd_i[2];
            act_q[i]    <= cmd_i[3];
            level_q[i]  <= cmd_i[9:8];
            chl_q[i]    <= cfg_chl;
            dly_q[i]    <= cfg_dly;
          end
        end
      end
      lvl_q   <= lvl_d;
      match_o <= fire;
      run_o   <= run_d;
      armed_o <= armed_d;
    end
  end
endmodule

// File: tb/tb_trigger_seq.sv
// Bench for trigger_seq: directed scenarios plus random traffic, all checked
// every cycle against a strobe-counting behavioural model.
module tb_trigger_seq;
  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst_i, set_mask_i, set_val_i, set_cfg_i, arm_i, disarm_i, stb_i;
  logic [31:0] cmd_i;
  logic [1:0]  sel_i;
  logic [7:0]  smpls_i;
  logic [3:0]  match_o;
  logic        run_o;
  logic [1:0]  lvl_o;
  logic        armed_o;

  always #5 clk = ~clk;

  trigger_seq #(.WIDTH(8), .NSTAGES(4), .DLY_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_i(cmd_i), .sel_i(sel_i),
    .set_mask_i(set_mask_i), .set_val_i(set_val_i), .set_cfg_i(set_cfg_i),
    .arm_i(arm_i), .disarm_i(disarm_i), .stb_i(stb_i), .smpls_i(smpls_i),
    .match_o(match_o), .run_o(run_o), .lvl_o(lvl_o), .armed_o(armed_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = idle, 1 = waiting for a match, 2 = counting strobes down.
  int unsigned m_mask[NS], m_val[NS], m_hist[NS], m_chl[NS], m_dly[NS], m_level[NS];
  int unsigned m_left[NS];
  bit          m_serial[NS], m_act[NS];
  int          m_mode[NS];
  int unsigned m_lvl = 0;
  int unsigned e_match = 0;
  bit          e_run = 0, e_armed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    int unsigned fired = 0;
    bit go = 0;
    if (rst_i) begin
      for (int i = 0; i < NS; i++) begin
        m_mask[i] = 0; m_val[i] = 0; m_hist[i] = 0; m_chl[i] = 0; m_dly[i] = 0;
        m_level[i] = 0; m_left[i] = 0; m_serial[i] = 0; m_act[i] = 0; m_mode[i] = 0;
      end
      m_lvl = 0; e_match = 0; e_run = 0; e_armed = 0;
      return;
    end
    for (int i = 0; i < NS; i++) begin
      int unsigned b  = (32'(smpls_i) >> m_chl[i]) & 1;
      int unsigned sv = ((m_hist[i] << 1) | b) & 32'hFF;
      int unsigned cv = m_serial[i] ? sv : 32'(smpls_i);
      if (stb_i && !arm_i && !disarm_i) begin
        if (m_mode[i] == 1) begin
          if (m_lvl >= m_level[i] && ((cv ^ m_val[i]) & m_mask[i]) == 0) begin
            if (m_dly[i] == 0) fired |= (1 << i);
            else begin m_mode[i] = 2; m_left[i] = m_dly[i]; end
          end
        end else if (m_mode[i] == 2) begin
          m_left[i]--;
          if (m_left[i] == 0) fired |= (1 << i);
        end
      end
      if (((fired >> i) & 1) != 0) begin
        m_mode[i] = 0;
        if (m_act[i]) go = 1;
      end
      if (stb_i) m_hist[i] = sv;
    end
    if (disarm_i) begin
      for (int i = 0; i < NS; i++) m_mode[i] = 0;
      m_lvl = 0;
    end else if (arm_i) begin
      for (int i = 0; i < NS; i++) m_mode[i] = 1;
      m_lvl = 0;
    end else if (go) begin
      for (int i = 0; i < NS; i++) m_mode[i] = 0;
    end else if (fired != 0 && m_lvl < 3) begin
      m_lvl++;
    end
    if (set_mask_i) m_mask[sel_i] = cmd_i & 32'hFF;
    if (set_val_i)  m_val[sel_i]  = cmd_i & 32'hFF;
    if (set_cfg_i) begin
      m_serial[sel_i] = cmd_i[2];
      m_act[sel_i]    = cmd_i[3];
      m_level[sel_i]  = (cmd_i >> 8) & 3;
      m_chl[sel_i]    = (((cmd_i & 1) << 4) | ((cmd_i >> 12) & 15)) & 7;
      m_dly[sel_i]    = (((cmd_i >> 16) & 255) << 8) | ((cmd_i >> 24) & 255);
    end
    e_match = fired;
    e_run   = go;
    e_armed = 0;
    for (int i = 0; i < NS; i++) if (m_mode[i] != 0) e_armed = 1;
  endfunction

  task automatic clear_in();
    rst_i = 0; set_mask_i = 0; set_val_i = 0; set_cfg_i = 0;
    arm_i = 0; disarm_i = 0; stb_i = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("match", 32'(match_o), e_match);
    check("run",   32'(run_o),   32'(e_run));
    check("lvl",   32'(lvl_o),   m_lvl);
    check("armed", 32'(armed_o), 32'(e_armed));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [7:0] v);
    stb_i = 1; smpls_i = v; tick(); stb_i = 0;
  endtask

  task automatic wr(input int s, input int kind, input logic [31:0] d);
    sel_i = 2'(s); cmd_i = d;
    set_mask_i = (kind == 0); set_val_i = (kind == 1); set_cfg_i = (kind == 2);
    tick();
    set_mask_i = 0; set_val_i = 0; set_cfg_i = 0;
  endtask

  task automatic arm();
    arm_i = 1; tick(); arm_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; tick(); rst_i = 0;
  endtask

  function automatic logic [31:0] cfg(input bit ser, input bit act, input int lvl,
                                      input int chl, input int dly);
    logic [31:0] c;
    c        = '0;
    c[2]     = ser;
    c[3]     = act;
    c[9:8]   = lvl[1:0];
    c[0]     = chl[4];
    c[15:12] = chl[3:0];
    c[23:16] = dly[15:8];
    c[31:24] = dly[7:0];
    return c;
  endfunction

  // Keeps an unused stage from firing: needs level 3 and sample 0xFF.
  task automatic park(input int s);
    wr(s, 0, 32'hFF); wr(s, 1, 32'hFF); wr(s, 2, cfg(0, 0, 3, 0, 0));
  endtask

  task automatic setup_a5(input int dly);
    do_reset();
    wr(0, 0, 32'hFF); wr(0, 1, 32'hA5); wr(0, 2, cfg(0, 1, 0, 0, dly));
    for (int s = 1; s < NS; s++) park(s);
  endtask

  initial begin
    clear_in();
    cmd_i = '0; sel_i = '0; smpls_i = '0;

    // reset state
    do_reset();
    check("rst_match", 32'(match_o), 32'h0);
    check("rst_armed", 32'(armed_o), 32'h0);

    // 1: parallel immediate fire
    setup_a5(0);
    arm();
    check("t1_armed", 32'(armed_o), 32'h1);
    strobe(8'h00);
    check("t1_run_early", 32'(run_o), 32'h0);
    strobe(8'hA5);
    check("t1_run", 32'(run_o), 32'h1);
    check("t1_match", 32'(match_o), 32'h1);
    check("t1_armed_off", 32'(armed_o), 32'h0);
    check("t1_lvl", 32'(lvl_o), 32'h0);
    idle(1);
    check("t1_run_pulse", 32'(run_o), 32'h0);

    // 2: delay 3 with idle gaps
    setup_a5(3);
    arm();
    strobe(8'hA5);
    idle(2);
    strobe(8'h00);
    check("t2_run1", 32'(run_o), 32'h0);
    idle(1);
    strobe(8'h00);
    check("t2_run2", 32'(run_o), 32'h0);
    check("t2_armed", 32'(armed_o), 32'h1);
    idle(3);
    strobe(8'h00);
    check("t2_run3", 32'(run_o), 32'h1);

    // 3: two-level chain
    do_reset();
    wr(0, 0, 32'hFF); wr(0, 1, 32'h01); wr(0, 2, cfg(0, 0, 0, 0, 0));
    wr(1, 0, 32'hFF); wr(1, 1, 32'h02); wr(1, 2, cfg(0, 1, 1, 0, 0));
    park(2); park(3);
    arm();
    strobe(8'h02);
    check("t3_none", 32'(match_o), 32'h0);
    strobe(8'h01);
    check("t3_lvl", 32'(lvl_o), 32'h1);
    check("t3_m0", 32'(match_o), 32'h1);
    strobe(8'h02);
    check("t3_run", 32'(run_o), 32'h1);
    check("t3_m1", 32'(match_o), 32'h2);

    // 4: serial on channel 5, pattern 1011
    do_reset();
    wr(0, 0, 32'h0F); wr(0, 1, 32'h0B); wr(0, 2, cfg(1, 1, 0, 5, 0));
    for (int s = 1; s < NS; s++) park(s);
    arm();
    strobe(8'h20); check("t4_s1", 32'(run_o), 32'h0);
    strobe(8'h00); check("t4_s2", 32'(run_o), 32'h0);
    strobe(8'h20); check("t4_s3", 32'(run_o), 32'h0);
    strobe(8'h20); check("t4_s4", 32'(run_o), 32'h1);

    // 5a: simultaneous fire increments once
    do_reset();
    for (int s = 0; s < 2; s++) begin
      wr(s, 0, 32'hFF); wr(s, 1, 32'h33); wr(s, 2, cfg(0, 0, 0, 0, 0));
    end
    park(2); park(3);
    arm();
    strobe(8'h33);
    check("t5_match", 32'(match_o), 32'h3);
    check("t5_lvl", 32'(lvl_o), 32'h1);

    // 5b: staggered delays drive the level to saturation
    do_reset();
    for (int s = 0; s < NS; s++) wr(s, 2, cfg(0, 0, 0, 0, s));
    arm();
    strobe(8'h5C); check("t5_l1", 32'(lvl_o), 32'h1);
    strobe(8'h00); check("t5_l2", 32'(lvl_o), 32'h2);
    strobe(8'h00); check("t5_l3", 32'(lvl_o), 32'h3);
    strobe(8'h00);
    check("t5_sat", 32'(lvl_o), 32'h3);
    check("t5_m3", 32'(match_o), 32'h8);

    // 6: abort paths
    setup_a5(5);
    arm();
    strobe(8'hA5);
    strobe(8'h00);
    disarm_i = 1; tick(); disarm_i = 0;
    check("t6_dis_armed", 32'(armed_o), 32'h0);
    check("t6_dis_lvl", 32'(lvl_o), 32'h0);
    for (int k = 0; k < 6; k++) strobe(8'h00);
    check("t6_dis_run", 32'(run_o), 32'h0);
    arm_i = 1; disarm_i = 1; tick(); arm_i = 0; disarm_i = 0;
    check("t6_both", 32'(armed_o), 32'h0);
    arm();
    strobe(8'hA5);
    strobe(8'h00);
    do_reset();
    check("t6_rst_armed", 32'(armed_o), 32'h0);
    check("t6_rst_run", 32'(run_o), 32'h0);
    for (int k = 0; k < 6; k++) strobe(8'h00);
    check("t6_rst_norun", 32'(run_o), 32'h0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      int unsigned r = $urandom_range(0, 199);
      clear_in();
      rst_i    = (r == 0);
      arm_i    = (r >= 1 && r <= 6) || r == 7;
      disarm_i = (r == 7) || (r == 8);
      if (r >= 10 && r < 40) begin
        int kind = $urandom_range(0, 2);
        sel_i = 2'($urandom_range(0, 3));
        if (kind == 2) begin
          cmd_i = cfg(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 4))
                  | ($urandom & 32'h00000CF2);
          set_cfg_i = 1;
        end else begin
          cmd_i = $urandom & $urandom;
          set_mask_i = (kind == 0);
          set_val_i  = (kind == 1);
        end
      end
      stb_i   = ($urandom_range(0, 9) < 7);
      smpls_i = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3));
      tick();
    end
    clear_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
